// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: clips rasterizer points, linearises {y,x} to a word
// address, queues writes in a FIFO and tracks per-triangle drain completion.
module fb_pixel_writer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int ADDR_WIDTH    = 19,
  parameter int COLOR_WIDTH   = 16,
  parameter int DEPTH         = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_write,
  input  logic [31:0]                  i_point,
  input  logic [COLOR_WIDTH-1:0]       i_color,
  input  logic                         i_raster_done,
  output logic                         o_mem_valid,
  output logic [ADDR_WIDTH-1:0]        o_mem_addr,
  output logic [COLOR_WIDTH-1:0]       o_mem_data,
  input  logic                         i_mem_ready,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_overflow,
  output logic                         o_clipped,
  output logic                         o_tri_done,
  output logic                         o_idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] WIDTH_U  = 32'(SCREEN_WIDTH);
  localparam logic [31:0] HEIGHT_U = 32'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [COLOR_WIDTH-1:0] color;
  } entry_t;

  state_t           state;
  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [15:0]      pt_x;
  logic [15:0]      pt_y;
  logic             in_range;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop_ovf;
  logic             drop_clip;
  logic             drain_done;

  assign pt_x       = i_point[15:0];
  assign pt_y       = i_point[31:16];
  assign fifo_full  = (o_count == CNT_W'(DEPTH));
  assign fifo_empty = (o_count == '0);
  assign head       = mem[rd_ptr];

  // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    in_range       = 1'b0;
    pop            = 1'b0;
    push           = 1'b0;
    drop_ovf       = 1'b0;
    drop_clip      = 1'b0;
    drain_done     = 1'b0;
    wr_entry.addr  = ADDR_WIDTH'(48'(pt_y) * 48'(WIDTH_U) + 48'(pt_x));
    wr_entry.color = i_color;

    in_range = ({16'd0, pt_x} < WIDTH_U) && ({16'd0, pt_y} < HEIGHT_U);
    // The output register refills whenever it is empty or being accepted.
    pop       = !fifo_empty && (!o_mem_valid || i_mem_ready);
    push      = i_write && in_range && (!fifo_full || pop);
    drop_clip = i_write && !in_range;
    drop_ovf  = i_write && in_range && fifo_full && !pop;
    // pop cannot happen with an empty FIFO, so a handshake here is never a reload.
    drain_done = fifo_empty && !push && (!o_mem_valid || i_mem_ready);
  end

  // NOTE: FIFO storage has no reset; clearing the pointers and count is what empties the queue.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // NOTE: sequential state uses <= so every register samples the pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
      o_overflow  <= 1'b0;
      o_clipped   <= 1'b0;
      o_tri_done  <= 1'b0;
      o_idle      <= 1'b1;
      state       <= S_IDLE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   o_count <= o_count + CNT_W'(1);
        2'b01:   o_count <= o_count - CNT_W'(1);
        default: o_count <= o_count;
      endcase

      if (pop) begin
        o_mem_valid <= 1'b1;
        o_mem_addr  <= head.addr;
        o_mem_data  <= head.color;
      end else if (i_mem_ready) begin
        o_mem_valid <= 1'b0;
      end

      if (drop_ovf) begin
        o_overflow <= 1'b1;
      end
      if (drop_clip) begin
        o_clipped <= 1'b1;
      end

      o_tri_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!i_raster_done) begin
            state  <= S_ACTIVE;
            o_idle <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (i_raster_done) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state      <= S_IDLE;
            o_idle     <= 1'b1;
            o_tri_done <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: vector table for single-cycle behaviour
// plus directed sequences for backpressure, triangle lifecycle and reset.
module tb_fb_pixel_writer;

  logic        i_clk;
  logic        i_reset;
  logic        i_write;
  logic [31:0] i_point;
  logic [15:0] i_color;
  logic        i_raster_done;
  logic        o_mem_valid;
  logic [18:0] o_mem_addr;
  logic [15:0] o_mem_data;
  logic        i_mem_ready;
  logic [4:0]  o_count;
  logic        o_overflow;
  logic        o_clipped;
  logic        o_tri_done;
  logic        o_idle;

  int passed;
  int total;

  fb_pixel_writer dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_write       (i_write),
    .i_point       (i_point),
    .i_color       (i_color),
    .i_raster_done (i_raster_done),
    .o_mem_valid   (o_mem_valid),
    .o_mem_addr    (o_mem_addr),
    .o_mem_data    (o_mem_data),
    .i_mem_ready   (i_mem_ready),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
    .o_clipped     (o_clipped),
    .o_tri_done    (o_tri_done),
    .o_idle        (o_idle)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [15:0] y;
    logic [15:0] x;
    logic [15:0] color;
    logic        ready;
    logic        exp_valid;
    logic [18:0] exp_addr;
    logic [15:0] exp_data;
    logic [4:0]  exp_count;
    logic        exp_clip;
    logic        exp_ovf;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset       = 1'b1;
    i_write       = 1'b0;
    i_raster_done = 1'b1;
    i_mem_ready   = 1'b0;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic [15:0] y, input logic [15:0] x, input logic [15:0] c);
    i_write = wr;
    i_point = {y, x};
    i_color = c;
  endtask

  initial begin
    int writes;
    int pulses;
    int last_hs;
    int tri_c;
    logic hs;

    passed        = 0;
    total         = 0;
    i_point       = '0;
    i_color       = '0;
    i_reset       = 1'b1;
    i_write       = 1'b0;
    i_raster_done = 1'b1;
    i_mem_ready   = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(o_mem_valid), 0);
    check("rst_addr", 32'(o_mem_addr), 0);
    check("rst_data", 32'(o_mem_data), 0);
    check("rst_count", 32'(o_count), 0);
    check("rst_overflow", 32'(o_overflow), 0);
    check("rst_clipped", 32'(o_clipped), 0);
    check("rst_tri_done", 32'(o_tri_done), 0);
    check("rst_idle", 32'(o_idle), 1);
    i_reset = 1'b0;

    // Single point, clipping at both bounds, far-corner address, push+pop together.
    vt[0] = '{1'b1, 16'd2,   16'd5,   16'hABCD, 1'b1, 1'b0, 19'd0,      16'h0000, 5'd1, 1'b0, 1'b0};
    vt[1] = '{1'b0, 16'd0,   16'd0,   16'h0000, 1'b1, 1'b1, 19'd1285,   16'hABCD, 5'd0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 16'd0,   16'd0,   16'h0000, 1'b1, 1'b0, 19'd0,      16'h0000, 5'd0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 16'd0,   16'd640, 16'h5555, 1'b1, 1'b0, 19'd0,      16'h0000, 5'd0, 1'b1, 1'b0};
    vt[4] = '{1'b1, 16'd480, 16'd0,   16'h5555, 1'b1, 1'b0, 19'd0,      16'h0000, 5'd0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 16'd479, 16'd639, 16'h1234, 1'b1, 1'b0, 19'd0,      16'h0000, 5'd1, 1'b1, 1'b0};
    vt[6] = '{1'b1, 16'd0,   16'd0,   16'h0001, 1'b1, 1'b1, 19'd307199, 16'h1234, 5'd1, 1'b1, 1'b0};
    vt[7] = '{1'b0, 16'd0,   16'd0,   16'h0000, 1'b1, 1'b1, 19'd0,      16'h0001, 5'd0, 1'b1, 1'b0};
    vt[8] = '{1'b0, 16'd0,   16'd0,   16'h0000, 1'b1, 1'b0, 19'd0,      16'h0000, 5'd0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].wr, vt[i].y, vt[i].x, vt[i].color);
      i_mem_ready = vt[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(o_mem_valid), 32'(vt[i].exp_valid));
      check($sformatf("vec%0d_count", i), 32'(o_count), 32'(vt[i].exp_count));
      check($sformatf("vec%0d_clipped", i), 32'(o_clipped), 32'(vt[i].exp_clip));
      check($sformatf("vec%0d_overflow", i), 32'(o_overflow), 32'(vt[i].exp_ovf));
      if (vt[i].exp_valid) begin
        check($sformatf("vec%0d_addr", i), 32'(o_mem_addr), 32'(vt[i].exp_addr));
        check($sformatf("vec%0d_data", i), 32'(o_mem_data), 32'(vt[i].exp_data));
      end
    end

    // Backpressure: 20 points into a stalled port, only 17 survive.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'(i), 16'(i + 1), 16'(16'h100 + i));
      tick();
    end
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    check("bp_count", 32'(o_count), 16);
    check("bp_overflow", 32'(o_overflow), 1);
    check("bp_valid", 32'(o_mem_valid), 1);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bp_stall_addr%0d", i), 32'(o_mem_addr), 1);
      check($sformatf("bp_stall_data%0d", i), 32'(o_mem_data), 32'h100);
      tick();
    end
    i_mem_ready = 1'b1;
    writes = 0;
    for (int c = 0; c < 40 && writes < 17; c++) begin
      if (o_mem_valid) begin
        check($sformatf("bp_w%0d_addr", writes), 32'(o_mem_addr), 32'(writes * 640 + writes + 1));
        check($sformatf("bp_w%0d_data", writes), 32'(o_mem_data), 32'(16'h100 + writes));
        writes++;
      end
      tick();
    end
    check("bp_writes", 32'(writes), 17);
    check("bp_empty_valid", 32'(o_mem_valid), 0);

    // Triangle lifecycle with alternating ready; done rises with the third point.
    do_reset();
    i_raster_done = 1'b0;
    tick();
    check("tri_active_idle", 32'(o_idle), 0);
    writes  = 0;
    pulses  = 0;
    last_hs = -1;
    tri_c   = -2;
    for (int c = 0; c < 30; c++) begin
      drive(c < 3, 16'd10, 16'(20 + c), 16'(16'h700 + c));
      i_raster_done = (c >= 2);
      i_mem_ready   = c[0];
      hs = o_mem_valid && i_mem_ready;
      tick();
      if (hs) begin
        writes++;
        last_hs = c;
      end
      if (o_tri_done) begin
        pulses++;
        tri_c = c;
      end
    end
    check("tri_writes", 32'(writes), 3);
    check("tri_pulses", 32'(pulses), 1);
    check("tri_pulse_timing", 32'(tri_c), 32'(last_hs));
    check("tri_end_idle", 32'(o_idle), 1);

    // Full FIFO with continuous push and pop.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 16'd1, 16'(i), 16'(i));
      tick();
    end
    check("pp_fill_count", 32'(o_count), 16);
    check("pp_fill_overflow", 32'(o_overflow), 0);
    i_mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'd2, 16'(i), 16'(i));
      tick();
      check($sformatf("pp_count%0d", i), 32'(o_count), 16);
    end
    check("pp_overflow", 32'(o_overflow), 0);

    // Reset mid-stream with 8 queued, a stalled request and a sticky clip flag.
    do_reset();
    i_raster_done = 1'b0;
    drive(1'b1, 16'd0, 16'd700, 16'd0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 16'd3, 16'(i), 16'(i));
      tick();
    end
    check("mr_pre_count", 32'(o_count), 8);
    check("mr_pre_valid", 32'(o_mem_valid), 1);
    check("mr_pre_clipped", 32'(o_clipped), 1);
    check("mr_pre_idle", 32'(o_idle), 0);
    i_reset       = 1'b1;
    i_raster_done = 1'b1;
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    tick();
    check("mr_valid", 32'(o_mem_valid), 0);
    check("mr_count", 32'(o_count), 0);
    check("mr_clipped", 32'(o_clipped), 0);
    check("mr_overflow", 32'(o_overflow), 0);
    check("mr_idle", 32'(o_idle), 1);
    check("mr_tri_done", 32'(o_tri_done), 0);
    i_reset     = 1'b0;
    i_mem_ready = 1'b1;
    pulses = 0;
    writes = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (o_tri_done) pulses++;
      if (o_mem_valid) writes++;
    end
    check("mr_post_tri_done", 32'(pulses), 0);
    check("mr_post_writes", 32'(writes), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Framebuffer pixel writer that sits directly downstream of the triangle rasterizer. It accepts the rasterizer's per-cycle point strobes, which carry no backpressure, and clips them to the screen. It converts `{y, x}` to a linear framebuffer address, buffers the writes in a FIFO, and issues them to the framebuffer memory port over a valid/ready handshake. It also tracks each triangle's lifetime and signals when every pixel of that triangle has been committed to memory.

## Interface
- `SCREEN_WIDTH`, 640: pixels per line; address multiplier and x clip bound.
- `SCREEN_HEIGHT`, 480: lines; y clip bound.
- `ADDR_WIDTH`, 19: framebuffer word address width; must satisfy 2^ADDR_WIDTH ≥ SCREEN_WIDTH*SCREEN_HEIGHT.
- `COLOR_WIDTH`, 16: pixel data width.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.

Ports:
- `i_clk` in 1: single clock; all logic on its rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_write` in 1: point strobe from the rasterizer, one point per cycle when high.
- `i_point` in 32: `{y[31:16], x[15:0]}`, unsigned integer pixel coordinates.
- `i_color` in COLOR_WIDTH: pixel colour, sampled together with `i_write`.
- `i_raster_done` in 1: rasterizer done level; low while a triangle is being walked.
- `o_mem_valid` out 1: memory write request.
- `o_mem_addr` out ADDR_WIDTH: word address, `y*SCREEN_WIDTH + x`.
- `o_mem_data` out COLOR_WIDTH: pixel colour.
- `i_mem_ready` in 1: memory accepts the request this cycle.
- `o_count` out $clog2(DEPTH)+1: FIFO occupancy; excludes the output register.
- `o_overflow` out 1: sticky; a point was dropped because the FIFO was full.
- `o_clipped` out 1: sticky; a point was discarded by clipping.
- `o_tri_done` out 1: one-cycle pulse when a triangle's writes are fully drained.
- `o_idle` out 1: high in IDLE state.

## Operation
- **Enqueue.** Happens on a cycle with `i_write`=1 when x < SCREEN_WIDTH, y < SCREEN_HEIGHT, and the FIFO is not full, or is full with a pop occurring in the same cycle.
  - The stored entry is `{addr, color}`.
  - `addr` is computed at enqueue as the full-width product `y*SCREEN_WIDTH + x`, then truncated to ADDR_WIDTH.
- **Clipping.** An off-screen point is discarded and sets `o_clipped`. Clipping takes precedence over the overflow check.
- **Overflow.** A point that is in range but arrives when the FIFO is full with no same-cycle pop is dropped and sets `o_overflow`. No other state is disturbed.
- **Output register.** `o_mem_valid`, `o_mem_addr` and `o_mem_data` form a single output register.
  - It loads from the FIFO head (pop) when the FIFO is non-empty and either `o_mem_valid`=0 or `i_mem_ready`=1.
  - While `o_mem_valid`=1 and `i_mem_ready`=0, addr and data hold stable.
  - `o_mem_valid` clears after a handshake when the FIFO is empty.
- **Simultaneous push and pop.** When both occur in one cycle, `o_count` is unchanged.
- **FSM.**
  - **IDLE** goes to ACTIVE when `i_raster_done`=0. Points arriving in IDLE are still accepted.
  - **ACTIVE** goes to DRAIN when `i_raster_done`=1. A last point arriving in the same cycle that done rises must be enqueued.
  - **DRAIN** goes to IDLE when the FIFO is empty, no push occurs this cycle, and either `o_mem_valid`=0 or `i_mem_ready`=1 with no reload. On this transition `o_tri_done` pulses high for exactly one cycle.
  - A done pulse of a single cycle is honoured: ACTIVE must have been entered for DRAIN to occur.

## Timing
- **Reset values.** On reset:
  - `o_mem_valid`=0, `o_mem_addr`=0, `o_mem_data`=0.
  - `o_count`=0, `o_overflow`=0, `o_clipped`=0.
  - `o_tri_done`=0, `o_idle`=1, state IDLE.
  - FIFO pointers cleared.
- **Reset mid-operation.** Reset discards all queued points and any pending request immediately; the memory side must tolerate an abandoned request.
- **Latency.**
  - `i_write` sampled at edge N with the FIFO empty: `o_mem_valid`=1 after edge N+1.
  - With `i_mem_ready` held at 1, sustained throughput is one write per cycle.
- **Occupancy and status timing.** `o_count` updates at the same edge as the push or pop. Sticky flags rise on the edge following the offending strobe.
- **Pointer wrap.** FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by occupancy or an extra pointer bit, not by pointer equality alone.
- **Multiplier.** Combinational or single-stage. If pipelined, enqueue latency grows accordingly and the latency line above must be amended.

## Test plan
- **Single point.** Reset; `i_write`=1 with point {y=2, x=5}, colour 0xABCD, `i_mem_ready`=1 → `o_mem_valid`=1 two edges later with addr 1285 and data 0xABCD, held for one cycle.
- **Backpressure.** `i_mem_ready`=0; 20 consecutive points → 16 queued plus 1 in the output register, `o_count`=16, `o_overflow`=1, and points 18–20 dropped. Releasing ready then yields 17 writes in order with addresses unchanged while stalled.
- **Clipping.** Points {y=0, x=640} and {y=480, x=0} → no memory writes, `o_clipped`=1, `o_overflow`=0.
- **Triangle lifecycle.** `i_raster_done` drops, 3 points arrive, then done rises in the same cycle as the 3rd point; ready alternates 0/1 → exactly 3 writes, followed by a single `o_tri_done` pulse one cycle after the last handshake and `o_idle`=1.
- **Simultaneous push/pop.** FIFO full with `i_mem_ready`=1 and `i_write`=1 each cycle for 10 cycles → no overflow, `o_count` stays 16.
- **Mid-stream reset.** Assert reset with 8 points queued and the request stalled → next cycle shows `o_mem_valid`=0, `o_count`=0, flags 0, `o_idle`=1, and no `o_tri_done`.
